// File: rtl/alu_pkg.sv
// Shared types and encodings for the EX-stage ALU control and mul/div unit.
package alu_pkg;

    // Widened ALU control codes; the legacy 3-bit codes keep MSB = 0.
    typedef enum logic [3:0] {
        CTRL_AND  = 4'b0000,
        CTRL_OR   = 4'b0001,
        CTRL_ADD  = 4'b0010,
        CTRL_SUB  = 4'b0011,
        CTRL_SLT  = 4'b0100,
        CTRL_NOR  = 4'b0101,
        CTRL_XOR  = 4'b0110,
        CTRL_SLTU = 4'b0111,
        CTRL_MFHI = 4'b1000,
        CTRL_MFLO = 4'b1001
    } alu_ctrl_e;

    // Main-decoder ALU op classes.
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_SUB    = 2'b11;

    // R-type funct encodings.
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // Mul/div sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_FIX  = 2'b11
    } md_state_e;

    // True for the four functs that start an iterative operation.
    function automatic logic is_md_op(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    // True for every funct that reads or writes HI/LO and must wait for them.
    function automatic logic is_hilo_user(input logic [5:0] f);
        return is_md_op(f) ||
               (f == FUNCT_MFHI) || (f == FUNCT_MFLO) ||
               (f == FUNCT_MTHI) || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// Operates on magnitudes only; sign handling lives in the parent.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic             is_div_q;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_sh_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // One iteration step: hi accumulates the partial product or remainder,
    // lo holds the multiplier being shifted out or the quotient shifted in.
    always_comb begin
        mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_sh_s   = {hi_q, lo_q[WIDTH-1]};
        div_diff_s = div_sh_s - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_diff_s[WIDTH]) begin
                hi_d = div_diff_s[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_sh_s[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum_s[WIDTH:1];
            lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Operand load on start, then WIDTH iteration steps counted by cnt_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            run_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else if (start_i) begin
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= a_i;
            b_q      <= b_i;
            is_div_q <= is_div_i;
            run_q    <= 1'b1;
            cnt_q    <= {CNT_W{1'b0}};
        end else if (abort_i) begin
            run_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else if (run_q) begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decode plus sequential mul/div with HI/LO registers
// and the pipeline stall request for HI/LO consumers.
module alu_muldiv_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [5:0]        funct_i,
    input  logic [1:0]        alu_op_i,
    input  logic [WIDTH-1:0]  rs_val_i,
    input  logic [WIDTH-1:0]  rt_val_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic              md_done_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);

    md_state_e        state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] rs_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             div0_q;
    logic             is_div_q;

    alu_ctrl_e        ctrl_s;
    logic             rtype_s;
    logic             accept_s;
    logic             mt_s;
    logic             is_signed_s;
    logic             is_div_s;
    logic             rs_neg_s;
    logic             rt_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             core_abort_s;
    logic             core_last_s;
    logic [WIDTH-1:0] core_hi_s;
    logic [WIDTH-1:0] core_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    // ALU control decode from op class and funct.
    always_comb begin
        ctrl_s = CTRL_ADD;
        case (alu_op_i)
            ALUOP_MEM, ALUOP_BRANCH: ctrl_s = CTRL_ADD;
            ALUOP_SUB:               ctrl_s = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_AND:  ctrl_s = CTRL_AND;
                    FUNCT_OR:   ctrl_s = CTRL_OR;
                    FUNCT_ADD:  ctrl_s = CTRL_ADD;
                    FUNCT_SUB:  ctrl_s = CTRL_SUB;
                    FUNCT_SLT:  ctrl_s = CTRL_SLT;
                    FUNCT_NOR:  ctrl_s = CTRL_NOR;
                    FUNCT_XOR:  ctrl_s = CTRL_XOR;
                    FUNCT_SLTU: ctrl_s = CTRL_SLTU;
                    FUNCT_MFHI: ctrl_s = CTRL_MFHI;
                    FUNCT_MFLO: ctrl_s = CTRL_MFLO;
                    default:    ctrl_s = CTRL_ADD;
                endcase
            end
            default: ctrl_s = CTRL_ADD;
        endcase
    end

    assign alu_ctrl_o = CTRL_W'(ctrl_s);

    // Handshake qualifiers; flush suppresses any new HI/LO activity.
    always_comb begin
        rtype_s  = valid_i && (alu_op_i == ALUOP_RTYPE);
        accept_s = rtype_s && is_md_op(funct_i) && !flush_i && (state_q == MD_IDLE);
        mt_s     = rtype_s && !flush_i && (state_q == MD_IDLE) &&
                   ((funct_i == FUNCT_MTHI) || (funct_i == FUNCT_MTLO));
    end

    assign stall_o = rtype_s && busy_q && is_hilo_user(funct_i);

    // Operand magnitudes; the unsigned variants have funct bit 0 set.
    always_comb begin
        is_signed_s = !funct_i[0];
        is_div_s    = funct_i[1];
        rs_neg_s    = is_signed_s && rs_val_i[WIDTH-1];
        rt_neg_s    = is_signed_s && rt_val_i[WIDTH-1];
        a_mag_s     = rs_neg_s ? (~rs_val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : rs_val_i;
        b_mag_s     = rt_neg_s ? (~rt_val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : rt_val_i;
    end

    assign core_abort_s = flush_i && ((state_q == MD_MUL) || (state_q == MD_DIV));

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept_s),
        .abort_i  (core_abort_s),
        .is_div_i (is_div_s),
        .a_i      (a_mag_s),
        .b_i      (b_mag_s),
        .last_o   (core_last_s),
        .hi_o     (core_hi_s),
        .lo_o     (core_lo_s)
    );

    // Sign correction and divide-by-zero override applied in the FIX cycle.
    always_comb begin
        prod_s = {core_hi_s, core_lo_s};
        if (is_div_q) begin
            if (div0_q) begin
                fix_hi_s = rs_q;
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_lo_s = neg_lo_q ? (~core_lo_s + {{(WIDTH-1){1'b0}}, 1'b1}) : core_lo_s;
                fix_hi_s = neg_hi_q ? (~core_hi_s + {{(WIDTH-1){1'b0}}, 1'b1}) : core_hi_s;
            end
        end else begin
            if (neg_lo_q) begin
                prod_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end else begin
                prod_s = prod_s;
            end
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer: accept, iterate, fix up, commit HI/LO; flush aborts silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            rs_q     <= {WIDTH{1'b0}};
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (accept_s) begin
                        state_q  <= is_div_s ? MD_DIV : MD_MUL;
                        busy_q   <= 1'b1;
                        rs_q     <= rs_val_i;
                        is_div_q <= is_div_s;
                        neg_lo_q <= rs_neg_s ^ rt_neg_s;
                        neg_hi_q <= rs_neg_s;
                        div0_q   <= (rt_val_i == {WIDTH{1'b0}});
                    end else if (mt_s) begin
                        if (funct_i[1]) begin
                            lo_q <= rs_val_i;
                        end else begin
                            hi_q <= rs_val_i;
                        end
                    end
                end
                MD_MUL, MD_DIV: begin
                    if (flush_i) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                    end else if (core_last_s) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state_q <= MD_IDLE;
                    busy_q  <= 1'b0;
                    if (!flush_i) begin
                        hi_q   <= fix_hi_s;
                        lo_q   <= fix_lo_s;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign md_done_o = done_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: decode table, mul/div results
// against an arithmetic reference, stall, flush and reset behaviour.
module tb_alu_muldiv_ctrl;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic [3:0]  alu_ctrl;
    logic        stall;
    logic        busy;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    alu_muldiv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid),
        .funct_i    (funct),
        .alu_op_i   (alu_op),
        .rs_val_i   (rs_val),
        .rt_val_i   (rt_val),
        .flush_i    (flush),
        .alu_ctrl_o (alu_ctrl),
        .stall_o    (stall),
        .busy_o     (busy),
        .md_done_o  (md_done),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decode reference straight from the instruction table.
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b11) return 4'd3;
        if (op != 2'b10) return 4'd2;
        case (f)
            6'b100100: return 4'd0;
            6'b100101: return 4'd1;
            6'b100000: return 4'd2;
            6'b100010: return 4'd3;
            6'b101010: return 4'd4;
            6'b100111: return 4'd5;
            6'b100110: return 4'd6;
            6'b101011: return 4'd7;
            6'b010000: return 4'd8;
            6'b010010: return 4'd9;
            default:   return 4'd2;
        endcase
    endfunction

    // Architectural mul/div results via plain wide arithmetic.
    task automatic ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        if (f == F_MULT) begin
            sp = longint'(sa) * longint'(sb);
            {rh, rl} = 64'(sp);
        end else if (f == F_MULTU) begin
            up = {32'h0, a} * {32'h0, b};
            {rh, rl} = up;
        end else if (b == 32'h0) begin
            rl = 32'hFFFF_FFFF;
            rh = a;
        end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            rl = 32'h8000_0000;
            rh = 32'h0;
        end else if (f == F_DIV) begin
            rl = 32'(sa / sb);
            rh = 32'(sa % sb);
        end else begin
            rl = a / b;
            rh = a % b;
        end
    endtask

    // Issue one mul/div and check the full 33-edge latency and result.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int early;
        valid  = 1'b1;
        alu_op = 2'b10;
        funct  = f;
        rs_val = a;
        rt_val = b;
        #1;
        chk({tag, " accept_stall"}, 64'(stall), 64'h0);
        tick();
        valid = 1'b0;
        funct = 6'h0;
        chk({tag, " busy_after_accept"}, 64'(busy), 64'h1);
        early = 0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (i < 33 && (md_done !== 1'b0 || busy !== 1'b1)) early++;
        end
        chk({tag, " early_done_or_idle"}, 64'(early), 64'h0);
        chk({tag, " done_pulse"}, 64'(md_done), 64'h1);
        chk({tag, " busy_end"}, 64'(busy), 64'h0);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        tick();
        chk({tag, " done_drop"}, 64'(md_done), 64'h0);
        m_hi = eh;
        m_lo = el;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  dec_f [10];
        logic [5:0]  md_f [4];
        logic [5:0]  f;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          cnt;

        dec_f = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                  6'b100111, 6'b100110, 6'b101011, 6'b010000, 6'b010010};
        md_f  = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

        rst = 1'b1; valid = 1'b0; funct = 6'h0; alu_op = 2'b00;
        rs_val = 32'h0; rt_val = 32'h0; flush = 1'b0;
        tick();
        tick();
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset done", 64'(md_done), 64'h0);
        chk("reset hi", 64'(hi), 64'h0);
        chk("reset lo", 64'(lo), 64'h0);
        rst = 1'b0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        tick();

        // Decode: every table funct, other op classes, random functs.
        for (int i = 0; i < 10; i++) begin
            alu_op = 2'b10;
            funct  = dec_f[i];
            #1;
            chk($sformatf("decode funct %b", dec_f[i]), 64'(alu_ctrl), 64'(ref_ctrl(2'b10, dec_f[i])));
        end
        for (int i = 0; i < 16; i++) begin
            op     = 2'($urandom_range(0, 3));
            f      = 6'($urandom_range(0, 63));
            alu_op = op;
            funct  = f;
            #1;
            chk($sformatf("decode op %b funct %b", op, f), 64'(alu_ctrl), 64'(ref_ctrl(op, f)));
        end
        alu_op = 2'b00;
        funct  = 6'h0;
        tick();

        // Directed results.
        run_md("mult",    F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("multu",   F_MULTU, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1);
        run_md("div",     F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu0",   F_DIVU,  32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF);
        run_md("div_ovf", F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            f = md_f[$urandom_range(0, 3)];
            a = pick_op();
            b = pick_op();
            ref_md(f, a, b, eh, el);
            run_md($sformatf("rand%0d f=%b a=%h b=%h", i, f, a, b), f, a, b, eh, el);
        end

        // Hazard: ADD proceeds while busy, MFLO stalls until the done edge.
        a = $urandom;
        b = $urandom;
        ref_md(F_MULT, a, b, eh, el);
        valid = 1'b1; alu_op = 2'b10; funct = F_MULT; rs_val = a; rt_val = b;
        tick();
        valid = 1'b0;
        tick();
        valid = 1'b1; funct = F_ADD;
        #1;
        chk("hazard add stall", 64'(stall), 64'h0);
        chk("hazard add ctrl", 64'(alu_ctrl), 64'h2);
        tick();
        funct = F_MFLO;
        cnt = 0;
        for (int j = 2; j <= 32; j++) begin
            #1;
            if (stall !== 1'b1) cnt++;
            tick();
        end
        chk("hazard mflo stall held", 64'(cnt), 64'h0);
        chk("hazard done", 64'(md_done), 64'h1);
        #1;
        chk("hazard mflo released", 64'(stall), 64'h0);
        chk("hazard lo", 64'(lo), 64'(el));
        chk("hazard hi", 64'(hi), 64'(eh));
        m_hi = eh;
        m_lo = el;
        valid = 1'b0;
        tick();

        // Flush ten cycles into a DIV: idle next edge, HI/LO untouched, no pulse.
        valid = 1'b1; alu_op = 2'b10; funct = F_DIV; rs_val = $urandom; rt_val = 32'h0000_0013;
        tick();
        valid = 1'b0;
        for (int j = 0; j < 9; j++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'h0);
        cnt = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (md_done !== 1'b0) cnt++;
        end
        chk("flush no done", 64'(cnt), 64'h0);
        chk("flush hi kept", 64'(hi), 64'(m_hi));
        chk("flush lo kept", 64'(lo), 64'(m_lo));

        // Flush together with an accept: nothing starts.
        valid = 1'b1; funct = F_MULTU; rs_val = $urandom; rt_val = $urandom; flush = 1'b1;
        tick();
        valid = 1'b0; flush = 1'b0;
        chk("flush+accept busy", 64'(busy), 64'h0);
        cnt = 0;
        for (int j = 0; j < 36; j++) begin
            tick();
            if (md_done !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("flush+accept quiet", 64'(cnt), 64'h0);
        chk("flush+accept lo kept", 64'(lo), 64'(m_lo));

        // MTHI / MTLO in idle.
        valid = 1'b1; funct = F_MTHI; rs_val = 32'h1234_5678;
        tick();
        valid = 1'b0;
        chk("mthi hi", 64'(hi), 64'h1234_5678);
        chk("mthi busy", 64'(busy), 64'h0);
        chk("mthi done", 64'(md_done), 64'h0);
        a = $urandom | 32'h1;
        valid = 1'b1; funct = F_MTLO; rs_val = a;
        tick();
        valid = 1'b0;
        chk("mtlo lo", 64'(lo), 64'(a));
        chk("mtlo hi kept", 64'(hi), 64'h1234_5678);

        // Reset in the middle of a MULT clears everything immediately.
        valid = 1'b1; funct = F_MULT; rs_val = $urandom; rt_val = $urandom;
        tick();
        valid = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 64'h0);
        chk("midrst hi", 64'(hi), 64'h0);
        chk("midrst lo", 64'(lo), 64'h0);
        chk("midrst done", 64'(md_done), 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Recovery after reset.
        a = $urandom;
        b = $urandom;
        ref_md(F_DIVU, a, b, eh, el);
        run_md("post_reset divu", F_DIVU, a, b, eh, el);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_ctrl.md
Name: alu_muldiv_ctrl

Overview:
- Second-generation ALU control for the MIPS core.
- Decodes funct/alu_op into a widened ALU control code that is a superset of the legacy 3-bit codes.
- Adds a sequential multiply/divide unit, radix-2 with one bit per cycle, plus architectural HI/LO registers.
- Sits beside the ALU in EX. Produces a stall request for the pipeline while HI/LO are not yet valid.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.
- CTRL_W, 4, ALU control code width; the legacy codes occupy the low 3 bits with the MSB at 0.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- valid_i  in  1  an instruction is present in EX.
- funct_i  in  6  instruction funct field.
- alu_op_i  in  2  main-decoder ALU op class.
- rs_val_i  in  WIDTH  rs operand.
- rt_val_i  in  WIDTH  rt operand.
- flush_i  in  1  abort any in-flight mul/div.
- alu_ctrl_o  out  CTRL_W  ALU control code (combinational).
- stall_o  out  1  hold EX (combinational).
- busy_o  out  1  mul/div in progress (registered).
- md_done_o  out  1  one-cycle pulse when HI/LO are updated by mul/div.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Decode for alu_op 00 and 01: ADD 0010. This is the legacy load/store behaviour.
- Decode for alu_op 11: SUB 0011.
- Decode for alu_op 10, by funct:
  - 100100 AND 0000
  - 100101 OR 0001
  - 100000 ADD 0010
  - 100010 SUB 0011
  - 101010 SLT 0100
  - 100111 NOR 0101
  - 100110 XOR 0110
  - 101011 SLTU 0111
  - 010000 MFHI 1000
  - 010010 MFLO 1001
  - any other funct: ADD 0010
- Mul/div functs: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
- Reset values: busy_o=0, md_done_o=0, hi_o=0, lo_o=0; FSM in IDLE.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept rule: a mul/div is accepted in IDLE when valid_i=1, alu_op_i=10, a mul/div funct is present, and flush_i=0.
  - Let the accept edge be k. Operands are latched at k; signed ops store magnitudes plus the result sign.
  - busy_o goes to 1 after edge k.
  - MUL/DIV each run WIDTH iteration cycles, then one FIX cycle applies sign correction.
  - hi_o/lo_o update at edge k+WIDTH+1. At that same edge md_done_o=1 for one cycle and busy_o=0.
- Multiply result: HI:LO is the 2*WIDTH-bit product.
- Divide result: LO is the quotient and HI the remainder.
  - Quotient is negative iff operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero, signed or unsigned: LO = all ones, HI = rs.
- Signed overflow (MIN / -1): LO = MIN, HI = 0.
- MTHI/MTLO in IDLE: write rs_val_i to HI or LO at the next edge. No busy; md_done_o stays 0.
- stall_o = valid_i and busy_o and the funct is in {MFHI, MFLO, MULT*, DIV*, MTHI, MTLO} with alu_op=10. Any other instruction proceeds while busy.
- The instruction that causes acceptance does not stall.
- flush_i=1 while busy: return to IDLE at the next edge. HI/LO keep their previous values; no md_done_o pulse.
- flush_i and an accept condition in the same cycle: flush wins and nothing is accepted.
- rst mid-operation: immediate return to IDLE with all outputs at their reset values.
- Mul/div requests are only accepted in IDLE. While busy, the stall prevents a second request.

Decomposition:
- Package alu_pkg holds:
  - alu_ctrl_e enum (CTRL_W bits, values above)
  - funct localparams
  - alu_op localparams
  - md_state_e enum
- Sub-module muldiv_core holds the iterative shift-add / restoring-divide datapath and its counter. The top holds decode, FSM handshake, sign handling and HI/LO.

Test Plan:
- Legacy regression: each legacy funct with alu_op=10, and alu_op 00/01 -> codes 0000..0101 and 0010. Then XOR -> 0110, SLTU -> 0111, MFHI -> 1000, MFLO -> 1001, alu_op=11 -> 0011.
- MULT: rs=FFFFFFFD, rt=00000005 -> after 33 edges hi_o=FFFFFFFF, lo_o=FFFFFFF1, with a single md_done_o pulse. MULTU with the same operands -> hi_o=00000004, lo_o=FFFFFFF1.
- DIV: rs=00000007, rt=FFFFFFFE -> lo_o=FFFFFFFD, hi_o=00000001. DIVU rs=00000009, rt=0 -> lo_o=FFFFFFFF, hi_o=00000009. DIV rs=80000000, rt=FFFFFFFF -> lo_o=80000000, hi_o=0.
- Hazard: issue MFLO 3 cycles after MULT -> stall_o=1 until the done edge, then 0. An ADD issued while busy -> stall_o=0.
- Abort: flush_i pulse 10 cycles into a DIV -> IDLE next edge, HI/LO unchanged, no md_done_o. Assert rst mid-MULT -> busy_o, hi_o and lo_o read 0 immediately.
- MTHI rs=12345678 in IDLE -> hi_o=12345678 after 1 edge, busy_o stays 0.
